// File: rtl/fetch_pc_ifid.sv
// Fetch stage: program counter, instruction-memory address and IF/ID register.
// Handles stall, flush and redirect from ID/EX; redirect has top priority.
module fetch_pc_ifid #(
    parameter int                 ADDR_W    = 12,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4,
    output logic              id_valid
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_id_pc;
    logic [ADDR_W-1:0] r_id_pc4;
    logic              r_valid;

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_bubble;

    // Sum wraps naturally at ADDR_W bits.
    assign w_pc4      = r_pc + ADDR_W'(4);
    assign w_redir_pc = redirect_pc_i & ~ADDR_W'(3);
    assign w_bubble   = redirect_i | flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= w_redir_pc;
        end else if (!stall_i) begin
            r_pc <= w_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr  <= NOP_INSTR;
            r_id_pc  <= '0;
            r_id_pc4 <= '0;
            r_valid  <= 1'b0;
        end else if (w_bubble) begin
            r_instr  <= NOP_INSTR;
            r_id_pc  <= '0;
            r_id_pc4 <= '0;
            r_valid  <= 1'b0;
        end else if (!stall_i) begin
            r_instr  <= imem_data;
            r_id_pc  <= r_pc;
            r_id_pc4 <= w_pc4;
            r_valid  <= 1'b1;
        end
    end

    assign imem_addr = r_pc;
    assign id_instr  = r_instr;
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc4;
    assign id_valid  = r_valid;

endmodule
